switch_debounce: RTL and testbench
==================================

# switch_debounce

Input conditioner for the board's 8 slide switches, the input side of the switch-to-LED path. Each raw switch is synchronized into `clk` and debounced with a per-bit stability counter. The block then outputs a clean switch state, one-cycle rise/fall strobes, and a latched change event with a valid/ack handshake. Downstream logic (LED drivers, mode controllers) consumes `sw_state` or the event interface instead of the raw pins.

## Interface
- `WIDTH`, 8: number of switch inputs.
- `DEBOUNCE_CYCLES`, 500000: consecutive clocks a new level must persist before acceptance (10 ms at 50 MHz). Legal range is 2 to 2^24.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `switch`  input  WIDTH  raw, asynchronous, bouncing switch levels.
- `sw_state`  output  WIDTH  debounced switch level.
- `sw_rise`  output  WIDTH  one-cycle strobe per bit when `sw_state` goes 0→1.
- `sw_fall`  output  WIDTH  one-cycle strobe per bit when `sw_state` goes 1→0.
- `event_valid`  output  1  a change event is pending.
- `event_mask`  output  WIDTH  bits that changed since the event opened.
- `event_state`  output  WIDTH  `sw_state` value after the most recent change folded into the event.
- `event_overrun`  output  1  some bit changed more than once within the pending event.
- `event_ack`  input  1  consumer acknowledges the pending event.

## Operation
- **Synchronizer:** two flops per bit, `sync1 <= switch`, then `sync2 <= sync1`. Only `sync2` feeds the debounce logic.
- **Counter size:** per-bit counter, width `$clog2(DEBOUNCE_CYCLES)`.
- **Counter rules, each edge, per bit:**
  - `sync2 == sw_state`: counter clears to 0.
  - `sync2 != sw_state` and counter < `DEBOUNCE_CYCLES-1`: counter increments.
  - `sync2 != sw_state` and counter == `DEBOUNCE_CYCLES-1`: `sw_state` bit takes `sync2` and counter clears.
- **Bounce rejection:** any single-cycle return to the old level restarts the count from 0.
- **Strobes:** `sw_rise`/`sw_fall` are registered and asserted in the same cycle `sw_state` changes. They are high for exactly one cycle and never both set on one bit.
- **Per-edge change vector:** `chg` = bits whose `sw_state` updates on this edge.
- **Event register, each edge, in priority order:**
  1. `event_valid=0` or `event_ack=1`, and `chg != 0`:
     - `event_valid <= 1`, `event_mask <= chg`;
     - `event_state <=` new `sw_state`, `event_overrun <= 0`.
  2. `event_ack=1`, `chg == 0`: `event_valid <= 0`, `event_mask <= 0`, `event_overrun <= 0`; `event_state` holds.
  3. `event_valid=1`, `event_ack=0`, `chg != 0`:
     - `event_mask <= event_mask | chg`;
     - `event_state <=` new `sw_state`;
     - `event_overrun <= event_overrun | (|(event_mask & chg))`.
  4. Otherwise all event outputs hold.
- **Ack while idle:** `event_ack` with `event_valid=0` has no effect except through case 1.
- **Power-up report:** switches already high at reset deassertion are reported as rises after the debounce latency. This is how power-up positions reach downstream logic.

## Timing
- **Reset values:** `sw_state`, `sw_rise`, `sw_fall`, `event_valid`, `event_mask`, `event_state`, `event_overrun` all 0. Synchronizers and counters are 0.
- **Reset mid-count:** asserting `rst` mid-count discards the partial count. Asserting it with an event pending drops the event.
- **Latency:** a clean level change first sampled by `sync1` at edge N updates `sw_state` at edge N+1+`DEBOUNCE_CYCLES`. That is `DEBOUNCE_CYCLES+2` edges counting N. The strobe appears in the same cycle.
- **Event timing:**
  - `event_valid` rises on the same edge as the first `sw_state` change.
  - Ack is observed on an edge and `event_valid` is low after that edge.
  - Back-to-back events are possible with zero idle cycles.
- **Independence:** bits debounce independently, so several bits may update on one edge and appear together in `chg`.
- **Throughput:** at most one `sw_state` change per bit every `DEBOUNCE_CYCLES` clocks.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Clean rise on bit 0 at edge N** → `sw_state=8'h01` and `sw_rise=8'h01` for one cycle at edge N+5; `event_valid=1`, `event_mask=8'h01`, `event_state=8'h01`.
- **Bounce on bit 3 (high 3 cycles, low 1, high 3, then steady high)** → no change until 4 consecutive mismatched `sync2` samples; exactly one `sw_rise[3]` pulse; no `sw_fall`.
- **Bit 1 rises, no ack, bit 1 falls, bit 5 rises** → `event_mask=8'h22`, `event_state=8'h20`, `event_overrun=1`. Then ack → `event_valid=0`, `event_overrun=0`.
- **Ack asserted on the same edge bit 7 update lands** → `event_valid` stays 1, `event_mask=8'h80`, `event_overrun=0`.
- **`switch=8'hA5` held through reset release** → after 6 edges `sw_state=8'hA5`, `sw_rise=8'hA5` for one cycle, `event_mask=8'hA5`.
- **`rst` asserted for 1 cycle mid-count with an event pending** → all outputs 0 immediately (asynchronous). The count restarts and the full latency is observed again after release.

Source files
------------

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus per-bit stability counter for the slide switches.
// Produces the debounced level, rise/fall strobes and a latched change event with valid/ack.
module switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             event_valid,
  output logic [WIDTH-1:0] event_mask,
  output logic [WIDTH-1:0] event_state,
  output logic             event_overrun,
  input  logic             event_ack
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= switch;
      sync2_reg <= sync1_reg;
    end
  end

  // Each bit restarts its count whenever the synchronized level matches the accepted one.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (sync2_reg[gi] == sw_state[gi]) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      assign chg[gi] = (sync2_reg[gi] != sw_state[gi]) && (cnt_reg == CNT_MAX);
    end
  endgenerate

  assign state_next = sw_state ^ chg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_state <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
    end else begin
      sw_state <= state_next;
      sw_rise  <= chg & state_next;
      sw_fall  <= chg & ~state_next;
    end
  end

  logic             ev_valid_next;
  logic [WIDTH-1:0] ev_mask_next;
  logic [WIDTH-1:0] ev_state_next;
  logic             ev_overrun_next;

  // A new change wins over a simultaneous ack so no update is ever lost.
  always_comb begin
    ev_valid_next   = event_valid;
    ev_mask_next    = event_mask;
    ev_state_next   = event_state;
    ev_overrun_next = event_overrun;
    if ((!event_valid || event_ack) && (|chg)) begin
      ev_valid_next   = 1'b1;
      ev_mask_next    = chg;
      ev_state_next   = state_next;
      ev_overrun_next = 1'b0;
    end else if (event_ack) begin
      ev_valid_next   = 1'b0;
      ev_mask_next    = '0;
      ev_overrun_next = 1'b0;
    end else if (event_valid && (|chg)) begin
      ev_mask_next    = event_mask | chg;
      ev_state_next   = state_next;
      ev_overrun_next = event_overrun | (|(event_mask & chg));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_valid   <= 1'b0;
      event_mask    <= '0;
      event_state   <= '0;
      event_overrun <= 1'b0;
    end else begin
      event_valid   <= ev_valid_next;
      event_mask    <= ev_mask_next;
      event_state   <= ev_state_next;
      event_overrun <= ev_overrun_next;
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4; inputs change 1 ns after a rising
// edge and outputs are sampled 1 ns after the edge.
module tb_switch_debounce;

  logic       clk;
  logic       rst;
  logic [7:0] switch;
  logic [7:0] sw_state;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       event_valid;
  logic [7:0] event_mask;
  logic [7:0] event_state;
  logic       event_overrun;
  logic       event_ack;

  int n_checks = 0;
  int n_fail   = 0;

  switch_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .switch(switch),
    .sw_state(sw_state), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .event_valid(event_valid), .event_mask(event_mask), .event_state(event_state),
    .event_overrun(event_overrun), .event_ack(event_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_ack();
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; switch = 8'h00; event_ack = 1'b0;
    repeat (2) tick();
    n_checks++; if (sw_state !== 8'h00) begin n_fail++; $display("FAIL reset_state: got %h expected %h", sw_state, 8'h00); end
    n_checks++; if ({sw_rise, sw_fall} !== 16'h0) begin n_fail++; $display("FAIL reset_strobes: got %h expected %h", {sw_rise, sw_fall}, 16'h0); end
    n_checks++; if ({event_valid, event_mask, event_state, event_overrun} !== 18'h0) begin n_fail++; $display("FAIL reset_event: got %h expected %h", {event_valid, event_mask, event_state, event_overrun}, 18'h0); end
    rst = 1'b0;
    repeat (8) tick();
    n_checks++; if (sw_state !== 8'h00 || event_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %h/%b expected 00/0", sw_state, event_valid); end
    $display("test_reset done");
  endtask

  task automatic test_clean_rise();
    switch = 8'h01;
    repeat (5) tick();
    n_checks++; if (sw_state !== 8'h00) begin n_fail++; $display("FAIL rise_early: got %h expected %h", sw_state, 8'h00); end
    tick();
    n_checks++; if (sw_state !== 8'h01) begin n_fail++; $display("FAIL rise_state: got %h expected %h", sw_state, 8'h01); end
    n_checks++; if (sw_rise !== 8'h01 || sw_fall !== 8'h00) begin n_fail++; $display("FAIL rise_strobe: got %h/%h expected 01/00", sw_rise, sw_fall); end
    n_checks++; if (event_valid !== 1'b1 || event_mask !== 8'h01 || event_state !== 8'h01) begin n_fail++; $display("FAIL rise_event: got %b/%h/%h expected 1/01/01", event_valid, event_mask, event_state); end
    tick();
    n_checks++; if (sw_rise !== 8'h00 || sw_state !== 8'h01) begin n_fail++; $display("FAIL rise_one_cycle: got rise %h state %h expected 00/01", sw_rise, sw_state); end
    do_ack();
    n_checks++; if (event_valid !== 1'b0 || event_mask !== 8'h00 || event_state !== 8'h01) begin n_fail++; $display("FAIL rise_ack: got %b/%h/%h expected 0/00/01", event_valid, event_mask, event_state); end
    $display("test_clean_rise done");
  endtask

  task automatic test_bounce();
    int pat [14] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int rise_cnt = 0;
    int fall_cnt = 0;
    int rise_idx = -1;
    for (int i = 0; i < 14; i++) begin
      switch = {4'h0, pat[i] != 0, 3'b001};
      tick();
      if (sw_rise[3]) begin rise_cnt++; if (rise_idx < 0) rise_idx = i; end
      if (sw_fall != 8'h00) fall_cnt++;
    end
    n_checks++; if (rise_cnt !== 1) begin n_fail++; $display("FAIL bounce_rise_count: got %0d expected 1", rise_cnt); end
    n_checks++; if (fall_cnt !== 0) begin n_fail++; $display("FAIL bounce_fall_count: got %0d expected 0", fall_cnt); end
    n_checks++; if (rise_idx !== 9) begin n_fail++; $display("FAIL bounce_rise_edge: got %0d expected 9", rise_idx); end
    n_checks++; if (sw_state !== 8'h09 || event_mask !== 8'h08) begin n_fail++; $display("FAIL bounce_final: got %h/%h expected 09/08", sw_state, event_mask); end
    do_ack();
    $display("test_bounce done");
  endtask

  task automatic test_overrun();
    switch = 8'h00;
    do_reset();
    switch = 8'h02;
    repeat (6) tick();
    n_checks++; if (event_mask !== 8'h02 || event_state !== 8'h02 || event_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %h/%h/%b expected 02/02/0", event_mask, event_state, event_overrun); end
    repeat (2) tick();
    switch = 8'h20;
    repeat (6) tick();
    n_checks++; if (sw_rise !== 8'h20 || sw_fall !== 8'h02) begin n_fail++; $display("FAIL ovr_strobes: got %h/%h expected 20/02", sw_rise, sw_fall); end
    n_checks++; if (event_valid !== 1'b1 || event_mask !== 8'h22 || event_state !== 8'h20 || event_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_event: got %b/%h/%h/%b expected 1/22/20/1", event_valid, event_mask, event_state, event_overrun); end
    do_ack();
    n_checks++; if (event_valid !== 1'b0 || event_overrun !== 1'b0 || event_mask !== 8'h00) begin n_fail++; $display("FAIL ovr_ack: got %b/%b/%h expected 0/0/00", event_valid, event_overrun, event_mask); end
    $display("test_overrun done");
  endtask

  task automatic test_ack_collision();
    switch = 8'h00;
    do_reset();
    switch = 8'h40;
    repeat (6) tick();
    switch = 8'hC0;
    repeat (5) tick();
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
    n_checks++; if (sw_state !== 8'hC0 || sw_rise !== 8'h80) begin n_fail++; $display("FAIL coll_state: got %h/%h expected C0/80", sw_state, sw_rise); end
    n_checks++; if (event_valid !== 1'b1 || event_mask !== 8'h80 || event_state !== 8'hC0 || event_overrun !== 1'b0) begin n_fail++; $display("FAIL coll_event: got %b/%h/%h/%b expected 1/80/C0/0", event_valid, event_mask, event_state, event_overrun); end
    do_ack();
    n_checks++; if (event_valid !== 1'b0) begin n_fail++; $display("FAIL coll_ack: got %b expected 0", event_valid); end
    $display("test_ack_collision done");
  endtask

  task automatic test_powerup();
    rst = 1'b1;
    switch = 8'hA5;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    n_checks++; if (sw_state !== 8'h00) begin n_fail++; $display("FAIL pwr_early: got %h expected 00", sw_state); end
    tick();
    n_checks++; if (sw_state !== 8'hA5 || sw_rise !== 8'hA5) begin n_fail++; $display("FAIL pwr_state: got %h/%h expected A5/A5", sw_state, sw_rise); end
    n_checks++; if (event_valid !== 1'b1 || event_mask !== 8'hA5 || event_state !== 8'hA5) begin n_fail++; $display("FAIL pwr_event: got %b/%h/%h expected 1/A5/A5", event_valid, event_mask, event_state); end
    tick();
    n_checks++; if (sw_rise !== 8'h00) begin n_fail++; $display("FAIL pwr_one_cycle: got %h expected 00", sw_rise); end
    $display("test_powerup done");
  endtask

  task automatic test_reset_midcount();
    switch = 8'hA4;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_checks++; if ({sw_state, sw_rise, sw_fall} !== 24'h0) begin n_fail++; $display("FAIL mid_async_sw: got %h expected 0", {sw_state, sw_rise, sw_fall}); end
    n_checks++; if ({event_valid, event_mask, event_state, event_overrun} !== 18'h0) begin n_fail++; $display("FAIL mid_async_event: got %h expected 0", {event_valid, event_mask, event_state, event_overrun}); end
    tick();
    rst = 1'b0;
    repeat (5) tick();
    n_checks++; if (sw_state !== 8'h00) begin n_fail++; $display("FAIL mid_early: got %h expected 00", sw_state); end
    tick();
    n_checks++; if (sw_state !== 8'hA4 || sw_rise !== 8'hA4 || event_mask !== 8'hA4) begin n_fail++; $display("FAIL mid_relatch: got %h/%h/%h expected A4/A4/A4", sw_state, sw_rise, event_mask); end
    $display("test_reset_midcount done");
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    test_overrun();
    test_ack_collision();
    test_powerup();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
